// File: rtl/data_unloader.sv
// Streams num_lines 64-byte lines from a core's 32-bit data memory into
// Avalon-MM single-beat writes at memory_base_addr + line*64.
module data_unloader #(
  parameter int CORES      = 4,
  parameter int DMEM_DEPTH = 14
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   kick,
  output logic                                   busy,
  output logic                                   done,
  input  logic [63:0]                            memory_base_addr,
  input  logic [$clog2(CORES)-1:0]               target_core,
  input  logic [DMEM_DEPTH-4:0]                  num_lines,
  output logic [$clog2(CORES)+DMEM_DEPTH+1:0]    data_addr,
  output logic                                   data_re,
  input  logic [31:0]                            data_din,
  input  logic                                   m0_waitrequest,
  input  logic [511:0]                           m0_readdata,
  input  logic                                   m0_readdatavalid,
  output logic [2:0]                             m0_burstcount,
  output logic [511:0]                           m0_writedata,
  output logic [63:0]                            m0_address,
  output logic                                   m0_write,
  output logic                                   m0_read,
  output logic [63:0]                            m0_byteenable
);

  localparam int CS = $clog2(CORES);
  localparam int LW = DMEM_DEPTH - 3;
  localparam int AW = CS + DMEM_DEPTH + 2;

  typedef enum logic [1:0] {IDLE, READ, DRAIN, WRITE} state_t;

  state_t          r_state, w_state;
  logic            r_busy, w_busy;
  logic            r_done, w_done;
  logic            r_data_re, w_data_re;
  logic [AW-1:0]   r_data_addr, w_data_addr;
  logic            r_m0_write, w_m0_write;
  logic [63:0]     r_m0_address, w_m0_address;
  logic [63:0]     r_base, w_base;
  logic [CS-1:0]   r_core, w_core;
  logic [LW-1:0]   r_num, w_num;
  logic [LW-1:0]   r_line, w_line;
  logic [3:0]      r_word, w_word;
  logic [LW-1:0]   w_line_inc;
  logic            r_rd_pend;
  logic [3:0]      r_rd_word;
  logic [511:0]    r_wdata;
  logic            w_unused;

  assign w_line_inc = r_line + 1'b1;

  always_comb begin
    w_state      = r_state;
    w_busy       = r_busy;
    w_done       = 1'b0;
    w_data_re    = r_data_re;
    w_data_addr  = r_data_addr;
    w_m0_write   = r_m0_write;
    w_m0_address = r_m0_address;
    w_base       = r_base;
    w_core       = r_core;
    w_num        = r_num;
    w_line       = r_line;
    w_word       = r_word;
    case (r_state)
      IDLE: begin
        w_busy     = 1'b0;
        w_data_re  = 1'b0;
        w_m0_write = 1'b0;
        if (kick) begin
          w_base = memory_base_addr;
          w_core = target_core;
          w_num  = num_lines;
          w_line = '0;
          w_word = '0;
          if (num_lines == '0) begin
            w_done = 1'b1;
          end else begin
            w_state     = READ;
            w_busy      = 1'b1;
            w_data_re   = 1'b1;
            w_data_addr = {target_core, {(DMEM_DEPTH + 2){1'b0}}};
          end
        end
      end
      READ: begin
        if (r_word == 4'd15) begin
          w_state   = DRAIN;
          w_data_re = 1'b0;
        end else begin
          w_word      = r_word + 4'd1;
          w_data_addr = {r_core, r_line[LW-2:0], r_word + 4'd1, 2'b00};
        end
      end
      DRAIN: begin
        w_state      = WRITE;
        w_m0_write   = 1'b1;
        w_m0_address = r_base + (64'(r_line) << 6);
      end
      WRITE: begin
        if (!m0_waitrequest) begin
          w_m0_write = 1'b0;
          if (w_line_inc == r_num) begin
            w_state = IDLE;
            w_done  = 1'b1;
            w_busy  = 1'b0;
          end else begin
            w_state     = READ;
            w_line      = w_line_inc;
            w_word      = '0;
            w_data_re   = 1'b1;
            w_data_addr = {r_core, w_line_inc[LW-2:0], 4'd0, 2'b00};
          end
        end
      end
      default: w_state = IDLE;
    endcase
  end

  // Read data returns one cycle after the strobe, so the capture slot
  // is the word index that was on data_addr in the previous cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_data_re    <= 1'b0;
      r_data_addr  <= '0;
      r_m0_write   <= 1'b0;
      r_m0_address <= '0;
      r_base       <= '0;
      r_core       <= '0;
      r_num        <= '0;
      r_line       <= '0;
      r_word       <= '0;
      r_rd_pend    <= 1'b0;
      r_rd_word    <= '0;
      r_wdata      <= '0;
    end else begin
      r_state      <= w_state;
      r_busy       <= w_busy;
      r_done       <= w_done;
      r_data_re    <= w_data_re;
      r_data_addr  <= w_data_addr;
      r_m0_write   <= w_m0_write;
      r_m0_address <= w_m0_address;
      r_base       <= w_base;
      r_core       <= w_core;
      r_num        <= w_num;
      r_line       <= w_line;
      r_word       <= w_word;
      r_rd_pend    <= r_data_re;
      r_rd_word    <= r_data_addr[5:2];
      if (r_rd_pend) begin
        for (int unsigned i = 0; i < 16; i++) begin
          if (r_rd_word == 4'(i)) r_wdata[511 - 32*i -: 32] <= data_din;
        end
      end
    end
  end

  assign busy          = r_busy | kick;
  assign done          = r_done;
  assign data_re       = r_data_re;
  assign data_addr     = r_data_addr;
  assign m0_write      = r_m0_write;
  assign m0_read       = 1'b0;
  assign m0_burstcount = 3'd1;
  assign m0_address    = r_m0_address;
  assign m0_writedata  = r_wdata;
  assign m0_byteenable = r_m0_write ? '1 : '0;
  assign w_unused      = ^{m0_readdata, m0_readdatavalid};

endmodule
